// File: rtl/fifo_destruct_var_if.sv
// Stream bundle for fifo_destruct_var: wide word write side, single-lane read side.
// FIFO_DESTRUCT_LAST_EN adds the wr_last/rd_last frame markers.
interface fifo_destruct_var_if #(
   parameter int unsigned DSIZE = 8,
   parameter int unsigned NSIZE = 4
);
   localparam int unsigned CSIZE = $clog2(NSIZE + 1);

   logic [DSIZE*NSIZE-1:0] wr_data;
   logic [CSIZE-1:0]       wr_cnt;
   logic                   wr_vld;
   logic                   wr_ready;
   logic [DSIZE-1:0]       rd_data;
   logic                   rd_vld;
   logic                   rd_ready;
`ifdef FIFO_DESTRUCT_LAST_EN
   logic                   wr_last;
   logic                   rd_last;

   modport master (
      output wr_data, wr_cnt, wr_vld, wr_last, rd_ready,
      input  wr_ready, rd_data, rd_vld, rd_last
   );
   modport slave (
      input  wr_data, wr_cnt, wr_vld, wr_last, rd_ready,
      output wr_ready, rd_data, rd_vld, rd_last
   );
`else
   modport master (
      output wr_data, wr_cnt, wr_vld, rd_ready,
      input  wr_ready, rd_data, rd_vld
   );
   modport slave (
      input  wr_data, wr_cnt, wr_vld, rd_ready,
      output wr_ready, rd_data, rd_vld
   );
`endif
endinterface

// File: rtl/fifo_destruct_var.sv
// Wide-to-narrow width converter: accepts NSIZE-lane words with a valid-lane count and
// emits one lane per cycle. An active word plus one pending word keep the output stream
// gap-free across word boundaries. Optional frame markers under FIFO_DESTRUCT_LAST_EN.
module fifo_destruct_var #(
   parameter int unsigned DSIZE     = 8,
   parameter int unsigned NSIZE     = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic                clock,
   input logic                rst,
   fifo_destruct_var_if.slave bus_io
);
   localparam int unsigned CSIZE = $clog2(NSIZE + 1);
   localparam int unsigned WSIZE = DSIZE * NSIZE;

   typedef enum logic [1:0] {StEmpty, StActive, StFull} state_e;

   state_e           state_q, state_d;
   logic [WSIZE-1:0] act_data_q, act_data_d;
   logic [CSIZE-1:0] act_cnt_q, act_cnt_d;
   logic [WSIZE-1:0] pend_data_q, pend_data_d;
   logic [CSIZE-1:0] pend_cnt_q, pend_cnt_d;
   logic [CSIZE-1:0] ptr_q, ptr_d;
`ifdef FIFO_DESTRUCT_LAST_EN
   logic             act_last_q, act_last_d;
   logic             pend_last_q, pend_last_d;
`endif

   logic             wr_ready;
   logic             rd_vld;
   logic [CSIZE-1:0] wr_cnt_eff;
   logic             wr_take;
   logic             rd_fire;
   logic             is_final;
   logic             act_done;
   logic [CSIZE-1:0] lane_idx;
   logic [DSIZE-1:0] rd_data;

   // Handshake qualifiers; wr_ready depends only on reset and registered state.
   assign wr_ready   = !rst && (state_q != StFull);
   assign rd_vld     = (state_q != StEmpty);
   assign wr_cnt_eff = (bus_io.wr_cnt > CSIZE'(NSIZE)) ? CSIZE'(NSIZE) : bus_io.wr_cnt;
   // Zero-lane words complete the handshake but are otherwise dropped.
   assign wr_take    = bus_io.wr_vld && wr_ready && (wr_cnt_eff != '0);
   assign rd_fire    = rd_vld && bus_io.rd_ready;
   assign is_final   = (ptr_q == (act_cnt_q - CSIZE'(1)));
   assign act_done   = rd_fire && is_final;
   assign lane_idx   = MSB_FIRST ? (CSIZE'(NSIZE - 1) - ptr_q) : ptr_q;

   // Lane mux over the active word.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < int'(NSIZE); i++) begin
         if (CSIZE'(i) == lane_idx) begin
            rd_data = act_data_q[i*DSIZE +: DSIZE];
         end
      end
   end

   // Next-state: load, bypass, promote pending and lane pointer advance.
   always_comb begin
      state_d     = state_q;
      act_data_d  = act_data_q;
      act_cnt_d   = act_cnt_q;
      pend_data_d = pend_data_q;
      pend_cnt_d  = pend_cnt_q;
      ptr_d       = ptr_q;
`ifdef FIFO_DESTRUCT_LAST_EN
      act_last_d  = act_last_q;
      pend_last_d = pend_last_q;
`endif
      unique case (state_q)
         StEmpty: begin
            if (wr_take) begin
               act_data_d = bus_io.wr_data;
               act_cnt_d  = wr_cnt_eff;
               ptr_d      = '0;
`ifdef FIFO_DESTRUCT_LAST_EN
               act_last_d = bus_io.wr_last;
`endif
               state_d    = StActive;
            end
         end
         StActive: begin
            if (act_done) begin
               ptr_d = '0;
               if (wr_take) begin
                  // Final lane leaves while a new word arrives: load straight to active.
                  act_data_d = bus_io.wr_data;
                  act_cnt_d  = wr_cnt_eff;
`ifdef FIFO_DESTRUCT_LAST_EN
                  act_last_d = bus_io.wr_last;
`endif
               end else begin
                  state_d = StEmpty;
               end
            end else begin
               if (rd_fire) begin
                  ptr_d = ptr_q + CSIZE'(1);
               end
               if (wr_take) begin
                  pend_data_d = bus_io.wr_data;
                  pend_cnt_d  = wr_cnt_eff;
`ifdef FIFO_DESTRUCT_LAST_EN
                  pend_last_d = bus_io.wr_last;
`endif
                  state_d     = StFull;
               end
            end
         end
         StFull: begin
            if (act_done) begin
               act_data_d = pend_data_q;
               act_cnt_d  = pend_cnt_q;
               ptr_d      = '0;
`ifdef FIFO_DESTRUCT_LAST_EN
               act_last_d = pend_last_q;
`endif
               state_d    = StActive;
            end else if (rd_fire) begin
               ptr_d = ptr_q + CSIZE'(1);
            end
         end
         default: begin
            state_d = StEmpty;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q     <= StEmpty;
         act_data_q  <= '0;
         act_cnt_q   <= '0;
         pend_data_q <= '0;
         pend_cnt_q  <= '0;
         ptr_q       <= '0;
`ifdef FIFO_DESTRUCT_LAST_EN
         act_last_q  <= 1'b0;
         pend_last_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         act_data_q  <= act_data_d;
         act_cnt_q   <= act_cnt_d;
         pend_data_q <= pend_data_d;
         pend_cnt_q  <= pend_cnt_d;
         ptr_q       <= ptr_d;
`ifdef FIFO_DESTRUCT_LAST_EN
         act_last_q  <= act_last_d;
         pend_last_q <= pend_last_d;
`endif
      end
   end

   assign bus_io.wr_ready = wr_ready;
   assign bus_io.rd_vld   = rd_vld;
   assign bus_io.rd_data  = rd_data;
`ifdef FIFO_DESTRUCT_LAST_EN
   assign bus_io.rd_last  = rd_vld && is_final && act_last_q;
`endif

endmodule

// File: tb/tb_fifo_destruct_var.sv
// Directed bench for fifo_destruct_var (DSIZE=8, NSIZE=4). A second instance with
// MSB_FIRST=0 shadows the same stimulus to check lane order. Inputs are driven and
// outputs sampled on the falling edge.
module tb_fifo_destruct_var;
   logic clock;
   logic rst;
   int   n_checks;
   int   n_errors;

   fifo_destruct_var_if #(.DSIZE(8), .NSIZE(4)) bus ();
   fifo_destruct_var_if #(.DSIZE(8), .NSIZE(4)) bus_lsb ();

   assign bus_lsb.wr_data  = bus.wr_data;
   assign bus_lsb.wr_cnt   = bus.wr_cnt;
   assign bus_lsb.wr_vld   = bus.wr_vld;
   assign bus_lsb.rd_ready = bus.rd_ready;
`ifdef FIFO_DESTRUCT_LAST_EN
   assign bus_lsb.wr_last  = bus.wr_last;
`endif

   fifo_destruct_var #(.DSIZE(8), .NSIZE(4), .MSB_FIRST(1'b1)) u_dut (
      .clock  (clock),
      .rst    (rst),
      .bus_io (bus)
   );

   fifo_destruct_var #(.DSIZE(8), .NSIZE(4), .MSB_FIRST(1'b0)) u_dut_lsb (
      .clock  (clock),
      .rst    (rst),
      .bus_io (bus_lsb)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic test_reset();
      rst          = 1'b1;
      bus.wr_data  = 32'hDEADBEEF;
      bus.wr_cnt   = 3'd4;
      bus.wr_vld   = 1'b1;
      bus.rd_ready = 1'b1;
      repeat (3) begin
         @(negedge clock);
         n_checks++;
         if (bus.wr_ready !== 1'b0 || bus.rd_vld !== 1'b0 || bus.rd_data !== 8'h00) begin
            n_errors++;
            $display("FAIL reset: wr_ready=%b rd_vld=%b rd_data=%h, want 0 0 00",
                     bus.wr_ready, bus.rd_vld, bus.rd_data);
         end
      end
      rst        = 1'b0;
      bus.wr_vld = 1'b0;
      #1;
      n_checks++;
      if (bus.wr_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release: wr_ready=%b, want 1", bus.wr_ready);
      end
   endtask

   task automatic test_full_word();
      logic [7:0] exp_m [4];
      exp_m = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      bus.wr_data = 32'hA1B2C3D4;
      bus.wr_cnt  = 3'd4;
      bus.wr_vld  = 1'b1;
      @(negedge clock);
      bus.wr_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (bus.rd_vld !== 1'b1 || bus.rd_data !== exp_m[i]) begin
            n_errors++;
            $display("FAIL full_word_msb lane %0d: vld=%b data=%h, want 1 %h",
                     i, bus.rd_vld, bus.rd_data, exp_m[i]);
         end
         n_checks++;
         if (bus_lsb.rd_vld !== 1'b1 || bus_lsb.rd_data !== exp_m[3-i]) begin
            n_errors++;
            $display("FAIL full_word_lsb lane %0d: vld=%b data=%h, want 1 %h",
                     i, bus_lsb.rd_vld, bus_lsb.rd_data, exp_m[3-i]);
         end
         @(negedge clock);
      end
      n_checks++;
      if (bus.rd_vld !== 1'b0) begin
         n_errors++;
         $display("FAIL full_word_drain: rd_vld=%b, want 0", bus.rd_vld);
      end
   endtask

   task automatic test_back_to_back();
      bus.wr_data = 32'h01020304;
      bus.wr_cnt  = 3'd4;
      bus.wr_vld  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (i == 0) begin
            bus.wr_data = 32'h05060708;
         end
         if (i == 1) begin
            bus.wr_vld = 1'b0;
         end
         if (i == 2) begin
            n_checks++;
            if (bus.wr_ready !== 1'b0) begin
               n_errors++;
               $display("FAIL b2b_pending_ready: wr_ready=%b, want 0", bus.wr_ready);
            end
         end
         n_checks++;
         if (bus.rd_vld !== 1'b1 || bus.rd_data !== 8'(i + 1)) begin
            n_errors++;
            $display("FAIL b2b lane %0d: vld=%b data=%h, want 1 %h",
                     i, bus.rd_vld, bus.rd_data, 8'(i + 1));
         end
      end
      @(negedge clock);
      n_checks++;
      if (bus.rd_vld !== 1'b0 || bus.wr_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_drain: rd_vld=%b wr_ready=%b, want 0 1", bus.rd_vld, bus.wr_ready);
      end
   endtask

   task automatic test_counts();
      logic [7:0] exp_c [4];
      // cnt=2: only the top two lanes.
      bus.wr_data = 32'hAABBCCDD;
      bus.wr_cnt  = 3'd2;
      bus.wr_vld  = 1'b1;
      @(negedge clock);
      bus.wr_vld = 1'b0;
      n_checks++;
      if (bus.rd_vld !== 1'b1 || bus.rd_data !== 8'hAA) begin
         n_errors++;
         $display("FAIL cnt2 lane 0: vld=%b data=%h, want 1 aa", bus.rd_vld, bus.rd_data);
      end
      @(negedge clock);
      n_checks++;
      if (bus.rd_vld !== 1'b1 || bus.rd_data !== 8'hBB) begin
         n_errors++;
         $display("FAIL cnt2 lane 1: vld=%b data=%h, want 1 bb", bus.rd_vld, bus.rd_data);
      end
      @(negedge clock);
      n_checks++;
      if (bus.rd_vld !== 1'b0) begin
         n_errors++;
         $display("FAIL cnt2_end: rd_vld=%b, want 0", bus.rd_vld);
      end
      // cnt=0: accepted, nothing emitted.
      bus.wr_data = 32'h12345678;
      bus.wr_cnt  = 3'd0;
      bus.wr_vld  = 1'b1;
      n_checks++;
      if (bus.wr_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL cnt0_ready: wr_ready=%b, want 1", bus.wr_ready);
      end
      @(negedge clock);
      bus.wr_vld = 1'b0;
      repeat (2) begin
         n_checks++;
         if (bus.rd_vld !== 1'b0 || bus.wr_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL cnt0_discard: rd_vld=%b wr_ready=%b, want 0 1",
                     bus.rd_vld, bus.wr_ready);
         end
         @(negedge clock);
      end
      // cnt=7 clamps to 4 lanes.
      exp_c = '{8'h55, 8'h66, 8'h77, 8'h88};
      bus.wr_data = 32'h55667788;
      bus.wr_cnt  = 3'd7;
      bus.wr_vld  = 1'b1;
      @(negedge clock);
      bus.wr_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (bus.rd_vld !== 1'b1 || bus.rd_data !== exp_c[i]) begin
            n_errors++;
            $display("FAIL cnt7 lane %0d: vld=%b data=%h, want 1 %h",
                     i, bus.rd_vld, bus.rd_data, exp_c[i]);
         end
         @(negedge clock);
      end
      n_checks++;
      if (bus.rd_vld !== 1'b0) begin
         n_errors++;
         $display("FAIL cnt7_end: rd_vld=%b, want 0 (clamped to 4)", bus.rd_vld);
      end
      // Single-lane words back to back exercise the bypass load.
      exp_c = '{8'h11, 8'h22, 8'h33, 8'h00};
      bus.wr_cnt = 3'd1;
      bus.wr_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.wr_data = {exp_c[i], 24'h000000};
         n_checks++;
         if (bus.wr_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL cnt1_ready word %0d: wr_ready=%b, want 1", i, bus.wr_ready);
         end
         @(negedge clock);
         n_checks++;
         if (bus.rd_vld !== 1'b1 || bus.rd_data !== exp_c[i]) begin
            n_errors++;
            $display("FAIL cnt1 word %0d: vld=%b data=%h, want 1 %h",
                     i, bus.rd_vld, bus.rd_data, exp_c[i]);
         end
      end
      bus.wr_vld = 1'b0;
      @(negedge clock);
      n_checks++;
      if (bus.rd_vld !== 1'b0) begin
         n_errors++;
         $display("FAIL cnt1_end: rd_vld=%b, want 0", bus.rd_vld);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_b [4];
      int         idx;
      exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      idx = 0;
      bus.wr_data  = 32'hA1B2C3D4;
      bus.wr_cnt   = 3'd4;
      bus.wr_vld   = 1'b1;
      bus.rd_ready = 1'b1;
      @(negedge clock);
      bus.wr_vld = 1'b0;
      for (int cyc = 0; cyc < 7; cyc++) begin
         n_checks++;
         if (bus.rd_vld !== 1'b1 || bus.rd_data !== exp_b[idx]) begin
            n_errors++;
            $display("FAIL backpressure cyc %0d: vld=%b data=%h, want 1 %h",
                     cyc, bus.rd_vld, bus.rd_data, exp_b[idx]);
         end
         bus.rd_ready = ((cyc % 2) == 0);
         if (bus.rd_ready) begin
            idx++;
         end
         @(negedge clock);
      end
      bus.rd_ready = 1'b1;
      n_checks++;
      if (bus.rd_vld !== 1'b0 || idx != 4) begin
         n_errors++;
         $display("FAIL backpressure_end: rd_vld=%b lanes=%0d, want 0 4", bus.rd_vld, idx);
      end
   endtask

`ifdef FIFO_DESTRUCT_LAST_EN
   task automatic test_last();
      logic [7:0] exp_l [3];
      exp_l = '{8'h11, 8'h22, 8'h33};
      bus.wr_data = 32'h11223344;
      bus.wr_cnt  = 3'd3;
      bus.wr_last = 1'b1;
      bus.wr_vld  = 1'b1;
      @(negedge clock);
      bus.wr_vld  = 1'b0;
      bus.wr_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (bus.rd_vld !== 1'b1 || bus.rd_data !== exp_l[i] || bus.rd_last !== (i == 2)) begin
            n_errors++;
            $display("FAIL last lane %0d: vld=%b data=%h last=%b, want 1 %h %b",
                     i, bus.rd_vld, bus.rd_data, bus.rd_last, exp_l[i], (i == 2));
         end
         @(negedge clock);
      end
      n_checks++;
      if (bus.rd_vld !== 1'b0) begin
         n_errors++;
         $display("FAIL last_end: rd_vld=%b, want 0", bus.rd_vld);
      end
   endtask
`endif

   task automatic test_reset_mid_word();
      logic [7:0] exp_r [4];
      exp_r = '{8'h99, 8'h88, 8'h77, 8'h66};
      bus.wr_data = 32'hA1B2C3D4;
      bus.wr_cnt  = 3'd4;
      bus.wr_vld  = 1'b1;
      @(negedge clock);
      bus.wr_vld = 1'b0;
      @(negedge clock);
      n_checks++;
      if (bus.rd_vld !== 1'b1 || bus.rd_data !== 8'hB2) begin
         n_errors++;
         $display("FAIL midrst_pre: vld=%b data=%h, want 1 b2", bus.rd_vld, bus.rd_data);
      end
      rst = 1'b1;
      @(negedge clock);
      n_checks++;
      if (bus.rd_vld !== 1'b0 || bus.rd_data !== 8'h00 || bus.wr_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst: vld=%b data=%h wr_ready=%b, want 0 00 0",
                  bus.rd_vld, bus.rd_data, bus.wr_ready);
      end
      rst         = 1'b0;
      bus.wr_data = 32'h99887766;
      bus.wr_cnt  = 3'd4;
      bus.wr_vld  = 1'b1;
      #1;
      n_checks++;
      if (bus.wr_ready !== 1'b1 || bus.rd_vld !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst_release: wr_ready=%b rd_vld=%b, want 1 0",
                  bus.wr_ready, bus.rd_vld);
      end
      @(negedge clock);
      bus.wr_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (bus.rd_vld !== 1'b1 || bus.rd_data !== exp_r[i]) begin
            n_errors++;
            $display("FAIL midrst_next lane %0d: vld=%b data=%h, want 1 %h",
                     i, bus.rd_vld, bus.rd_data, exp_r[i]);
         end
         @(negedge clock);
      end
      n_checks++;
      if (bus.rd_vld !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst_drain: rd_vld=%b, want 0", bus.rd_vld);
      end
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst          = 1'b1;
      bus.wr_data  = '0;
      bus.wr_cnt   = '0;
      bus.wr_vld   = 1'b0;
      bus.rd_ready = 1'b1;
`ifdef FIFO_DESTRUCT_LAST_EN
      bus.wr_last  = 1'b0;
`endif
      test_reset();
      test_full_word();
      test_back_to_back();
      test_counts();
      test_backpressure();
`ifdef FIFO_DESTRUCT_LAST_EN
      test_last();
`endif
      test_reset_mid_word();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
